cordic_arbiter: RTL and testbench
=================================

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the per-component sample width (x, y, amplitude, phase).
REQ-002 SHALL have parameter MAX_OUT, default 8, meaning the maximum number of transactions in flight through the CORDIC core (power of 2).
REQ-003 SHALL have port aclk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_tvalid input 1, req0_tready output 1, req0_tdata input 2*DATA_W: requester 0 cartesian sample, packed {y,x}.
REQ-006 SHALL have ports req1_tvalid input 1, req1_tready output 1, req1_tdata input 2*DATA_W: requester 1 cartesian sample, packed {y,x}.
REQ-007 SHALL have ports cordic_s_tvalid output 1 and cordic_s_tdata output 2*DATA_W: drive s_axis_cartesian of the CORDIC core in translate mode.
REQ-008 SHALL have ports cordic_m_tvalid input 1 and cordic_m_tdata input 2*DATA_W: from m_axis_dout of the core, packed {phase,amp}.
REQ-009 SHALL have ports res0_tvalid output 1, res0_tdata output 2*DATA_W, res1_tvalid output 1, res1_tdata output 2*DATA_W: routed results, packed {phase,amp}; no backpressure.
REQ-010 SHALL have port outstanding, output, $clog2(MAX_OUT)+1 bits: in-flight count.
REQ-011 SHALL have port orphan_err, output, 1 bit: sticky flag, set when a result arrives with no tag.

Function
REQ-012 SHALL grant at most one requester per cycle, and only when outstanding < MAX_OUT.
REQ-013 SHALL arbitrate round-robin: the pointer starts at requester 0; after a grant to requester N, the pointer moves to the other requester; with one requester valid, that requester wins regardless of the pointer.
REQ-014 SHALL drive reqN_tready combinationally equal to grantN; a handshake is reqN_tvalid & reqN_tready.
REQ-015 SHALL, on a handshake in cycle t, present the sample on cordic_s_tdata with cordic_s_tvalid=1 in cycle t+1 (registered), for exactly one cycle per handshake.
REQ-016 SHALL push the granted requester ID (1 bit) into a MAX_OUT-deep tag FIFO on each handshake.
REQ-017 SHALL pop the tag FIFO on each cordic_m_tvalid, register cordic_m_tdata onto resN_tdata, and pulse resN_tvalid for one cycle at t+1, where N is the popped tag.
REQ-018 SHALL keep the result order identical to the CORDIC issue order; the core is in-order with fixed latency and does not need to be known.
REQ-019 SHALL increment outstanding on a push only, decrement it on a pop only, and leave it unchanged on a simultaneous push and pop.
REQ-020 SHALL, when outstanding == MAX_OUT and a pop occurs in the same cycle, still deassert tready in that cycle; the grant depends on the registered count.
REQ-021 SHALL, on cordic_m_tvalid with an empty tag FIFO, drop the result, leave res0_tvalid and res1_tvalid at 0, and set orphan_err, which stays set until rst.
REQ-022 SHALL never drive res0_tvalid and res1_tvalid high in the same cycle.
REQ-023 SHALL wrap the FIFO pointers modulo MAX_OUT with no other effect.

Reset
REQ-024 SHALL, while rst=1, force these values: cordic_s_tvalid=0, cordic_s_tdata=0, res0_tvalid=0, res1_tvalid=0, res0_tdata=0, res1_tdata=0, outstanding=0, orphan_err=0, req0_tready=0, req1_tready=0, RR pointer=0, tag FIFO empty.
REQ-025 SHALL, on reset during operation, discard all tags; results still draining from the core afterwards fall under REQ-021 (dropped, orphan_err set).
REQ-026 SHALL resume arbitration on the first rising edge of aclk after rst deasserts.

Verification
REQ-027 SHALL cover this scenario: req0 alone sends {y=0x2D,x=0x2D} -> cordic_s_tvalid one cycle later with data 0x2D2D; the core result returns on res0 only; outstanding goes 0 -> 1 -> 0.
REQ-028 SHALL cover this scenario: req0 and req1 held valid for 6 cycles -> grants alternate 0,1,0,1,0,1; results arrive on res0/res1 in the same alternating order.
REQ-029 SHALL cover this scenario: a stalled core (no cordic_m_tvalid) with MAX_OUT=8 and both requesters valid -> exactly 8 handshakes, then tready=0 and outstanding=8; one result -> one further grant.
REQ-030 SHALL cover this scenario: a push and a pop in the same cycle at outstanding=3 -> outstanding stays 3 and the tags route correctly.
REQ-031 SHALL cover this scenario: cordic_m_tvalid injected with an empty FIFO -> no resN_tvalid, orphan_err=1 until rst.
REQ-032 SHALL cover this scenario: rst asserted with 4 in flight -> all outputs 0 immediately; the 4 late results are dropped and orphan_err=1; new traffic routes correctly afterwards.

Source files
------------

// File: rtl/cordic_arbiter.sv
// Round-robin front end that shares one translate-mode CORDIC between two requesters and routes results back by tag.
// Issue and result are registered one cycle after handshake/arrival; tready drops while MAX_OUT transactions are in flight.
module cordic_arbiter #(
  parameter int DATA_W  = 8,
  parameter int MAX_OUT = 8
) (
  input  logic                         aclk,
  input  logic                         rst,
  input  logic                         req0_tvalid,
  output logic                         req0_tready,
  input  logic [2*DATA_W-1:0]          req0_tdata,
  input  logic                         req1_tvalid,
  output logic                         req1_tready,
  input  logic [2*DATA_W-1:0]          req1_tdata,
  output logic                         cordic_s_tvalid,
  output logic [2*DATA_W-1:0]          cordic_s_tdata,
  input  logic                         cordic_m_tvalid,
  input  logic [2*DATA_W-1:0]          cordic_m_tdata,
  output logic                         res0_tvalid,
  output logic [2*DATA_W-1:0]          res0_tdata,
  output logic                         res1_tvalid,
  output logic [2*DATA_W-1:0]          res1_tdata,
  output logic [$clog2(MAX_OUT):0]     outstanding,
  output logic                         orphan_err
);

  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  logic          rr_ptr;
  logic          tag_mem [MAX_OUT];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          can_grant;
  logic          grant0;
  logic          grant1;
  logic          push;
  logic          pop;
  logic          pop_tag;
  logic          fifo_empty;

  // Grant uses the registered count, so a pop in a full cycle cannot reopen tready early.
  always_comb begin
    fifo_empty = (outstanding == '0);
    can_grant  = !rst && (outstanding < MAX_CNT);
    grant0     = can_grant && req0_tvalid && (!req1_tvalid || !rr_ptr);
    grant1     = can_grant && req1_tvalid && (!req0_tvalid ||  rr_ptr);
    push       = grant0 || grant1;
    pop        = cordic_m_tvalid && !fifo_empty;
    pop_tag    = tag_mem[rd_ptr];
  end

  assign req0_tready = grant0;
  assign req1_tready = grant1;

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      rr_ptr          <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      outstanding     <= '0;
      cordic_s_tvalid <= 1'b0;
      cordic_s_tdata  <= '0;
      res0_tvalid     <= 1'b0;
      res0_tdata      <= '0;
      res1_tvalid     <= 1'b0;
      res1_tdata      <= '0;
      orphan_err      <= 1'b0;
    end else begin
      cordic_s_tvalid <= push;
      if (push) begin
        cordic_s_tdata <= grant1 ? req1_tdata : req0_tdata;
        rr_ptr         <= grant0;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      res0_tvalid <= pop && !pop_tag;
      res1_tvalid <= pop &&  pop_tag;
      if (pop && !pop_tag) res0_tdata <= cordic_m_tdata;
      if (pop &&  pop_tag) res1_tdata <= cordic_m_tdata;
      // A result with no tag left (e.g. draining after reset) is dropped.
      if (cordic_m_tvalid && fifo_empty) orphan_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: pointers and count define validity.
  always_ff @(posedge aclk) begin
    if (push) tag_mem[wr_ptr] <= grant1;
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed table plus hand-written sequences for the full, orphan and reset-in-flight cases.
module tb_cordic_arbiter;
  localparam int DW = 8;
  localparam int MO = 8;

  logic          aclk = 1'b0;
  logic          rst;
  logic          req0_tvalid, req1_tvalid, req0_tready, req1_tready;
  logic [15:0]   req0_tdata, req1_tdata;
  logic          cordic_s_tvalid, cordic_m_tvalid;
  logic [15:0]   cordic_s_tdata, cordic_m_tdata;
  logic          res0_tvalid, res1_tvalid;
  logic [15:0]   res0_tdata, res1_tdata;
  logic [3:0]    outstanding;
  logic          orphan_err;

  int checks = 0;
  int errors = 0;

  cordic_arbiter #(.DATA_W(DW), .MAX_OUT(MO)) dut (
    .aclk(aclk), .rst(rst),
    .req0_tvalid(req0_tvalid), .req0_tready(req0_tready), .req0_tdata(req0_tdata),
    .req1_tvalid(req1_tvalid), .req1_tready(req1_tready), .req1_tdata(req1_tdata),
    .cordic_s_tvalid(cordic_s_tvalid), .cordic_s_tdata(cordic_s_tdata),
    .cordic_m_tvalid(cordic_m_tvalid), .cordic_m_tdata(cordic_m_tdata),
    .res0_tvalid(res0_tvalid), .res0_tdata(res0_tdata),
    .res1_tvalid(res1_tvalid), .res1_tdata(res1_tdata),
    .outstanding(outstanding), .orphan_err(orphan_err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic v0, v1; logic [15:0] d0, d1; logic mv; logic [15:0] md;
    logic rdy0, rdy1; logic sv; logic [15:0] sd;
    logic r0v; logic [15:0] r0d; logic r1v; logic [15:0] r1d;
    logic [3:0] outc; logic orph;
  } vec_t;

  function automatic vec_t mk(logic v0, logic v1, logic [15:0] d0, logic [15:0] d1,
                              logic mv, logic [15:0] md, logic rdy0, logic rdy1,
                              logic sv, logic [15:0] sd, logic r0v, logic [15:0] r0d,
                              logic r1v, logic [15:0] r1d, logic [3:0] outc, logic orph);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1; v.mv = mv; v.md = md;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.sv = sv; v.sd = sd;
    v.r0v = r0v; v.r0d = r0d; v.r1v = r1v; v.r1d = r1d; v.outc = outc; v.orph = orph;
    return v;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_s_tvalid"}, cordic_s_tvalid, 0);
    chk({tag, "_s_tdata"}, cordic_s_tdata, 0);
    chk({tag, "_res0_tvalid"}, res0_tvalid, 0);
    chk({tag, "_res1_tvalid"}, res1_tvalid, 0);
    chk({tag, "_res0_tdata"}, res0_tdata, 0);
    chk({tag, "_res1_tdata"}, res1_tdata, 0);
    chk({tag, "_outstanding"}, outstanding, 0);
    chk({tag, "_orphan"}, orphan_err, 0);
    chk({tag, "_rdy0"}, req0_tready, 0);
    chk({tag, "_rdy1"}, req1_tready, 0);
  endtask

  vec_t tbl[21];
  int   hs;

  initial begin
    // Grants 0,1,0,1,0,1 then results routed in the same order
    tbl[0]  = mk(1,1,16'h1101,16'h2201, 0,16'h0, 1,0, 1,16'h1101, 0,16'h0,   0,16'h0,   1,0);
    tbl[1]  = mk(1,1,16'h1102,16'h2202, 0,16'h0, 0,1, 1,16'h2202, 0,16'h0,   0,16'h0,   2,0);
    tbl[2]  = mk(1,1,16'h1103,16'h2203, 0,16'h0, 1,0, 1,16'h1103, 0,16'h0,   0,16'h0,   3,0);
    tbl[3]  = mk(1,1,16'h1104,16'h2204, 0,16'h0, 0,1, 1,16'h2204, 0,16'h0,   0,16'h0,   4,0);
    tbl[4]  = mk(1,1,16'h1105,16'h2205, 0,16'h0, 1,0, 1,16'h1105, 0,16'h0,   0,16'h0,   5,0);
    tbl[5]  = mk(1,1,16'h1106,16'h2206, 0,16'h0, 0,1, 1,16'h2206, 0,16'h0,   0,16'h0,   6,0);
    tbl[6]  = mk(0,0,16'h0,16'h0, 1,16'hA001, 0,0, 0,16'h2206, 1,16'hA001, 0,16'h0,   5,0);
    tbl[7]  = mk(0,0,16'h0,16'h0, 1,16'hA002, 0,0, 0,16'h2206, 0,16'hA001, 1,16'hA002, 4,0);
    tbl[8]  = mk(0,0,16'h0,16'h0, 1,16'hA003, 0,0, 0,16'h2206, 1,16'hA003, 0,16'hA002, 3,0);
    // Push and pop together at outstanding=3
    tbl[9]  = mk(0,1,16'h0,16'h3301, 1,16'hA004, 0,1, 1,16'h3301, 0,16'hA003, 1,16'hA004, 3,0);
    tbl[10] = mk(0,0,16'h0,16'h0, 1,16'hA005, 0,0, 0,16'h3301, 1,16'hA005, 0,16'hA004, 2,0);
    tbl[11] = mk(0,0,16'h0,16'h0, 1,16'hA006, 0,0, 0,16'h3301, 0,16'hA005, 1,16'hA006, 1,0);
    tbl[12] = mk(0,0,16'h0,16'h0, 1,16'hA007, 0,0, 0,16'h3301, 0,16'hA005, 1,16'hA007, 0,0);
    // Single req0 sample 0x2D2D round trip
    tbl[13] = mk(1,0,16'h2D2D,16'h0, 0,16'h0, 1,0, 1,16'h2D2D, 0,16'hA005, 0,16'hA007, 1,0);
    tbl[14] = mk(0,0,16'h0,16'h0, 0,16'h0, 0,0, 0,16'h2D2D, 0,16'hA005, 0,16'hA007, 1,0);
    tbl[15] = mk(0,0,16'h0,16'h0, 1,16'h1A40, 0,0, 0,16'h2D2D, 1,16'h1A40, 0,16'hA007, 0,0);
    tbl[16] = mk(0,0,16'h0,16'h0, 0,16'h0, 0,0, 0,16'h2D2D, 0,16'h1A40, 0,16'hA007, 0,0);
    // Pointer now favours req1, but a lone req0 still wins
    tbl[17] = mk(1,0,16'h4401,16'h0, 0,16'h0, 1,0, 1,16'h4401, 0,16'h1A40, 0,16'hA007, 1,0);
    tbl[18] = mk(0,0,16'h0,16'h0, 1,16'hB001, 0,0, 0,16'h4401, 1,16'hB001, 0,16'hA007, 0,0);
    // Result with empty tag FIFO: dropped, sticky orphan flag
    tbl[19] = mk(0,0,16'h0,16'h0, 1,16'hC0DE, 0,0, 0,16'h4401, 0,16'hB001, 0,16'hA007, 0,1);
    tbl[20] = mk(0,0,16'h0,16'h0, 0,16'h0, 0,0, 0,16'h4401, 0,16'hB001, 0,16'hA007, 0,1);

    rst = 1'b1;
    req0_tvalid = 1'b1; req1_tvalid = 1'b1;
    req0_tdata = 16'h0; req1_tdata = 16'h0;
    cordic_m_tvalid = 1'b0; cordic_m_tdata = 16'h0;
    #12;
    all_zero("reset");
    @(negedge aclk);
    rst = 1'b0; req0_tvalid = 1'b0; req1_tvalid = 1'b0;
    @(posedge aclk); #1;

    for (int i = 0; i < 21; i++) begin
      req0_tvalid = tbl[i].v0; req1_tvalid = tbl[i].v1;
      req0_tdata = tbl[i].d0;  req1_tdata = tbl[i].d1;
      cordic_m_tvalid = tbl[i].mv; cordic_m_tdata = tbl[i].md;
      #1;
      chk($sformatf("v%0d_rdy0", i), req0_tready, tbl[i].rdy0);
      chk($sformatf("v%0d_rdy1", i), req1_tready, tbl[i].rdy1);
      @(posedge aclk); #1;
      chk($sformatf("v%0d_s_tvalid", i), cordic_s_tvalid, tbl[i].sv);
      chk($sformatf("v%0d_s_tdata", i), cordic_s_tdata, tbl[i].sd);
      chk($sformatf("v%0d_res0_tvalid", i), res0_tvalid, tbl[i].r0v);
      chk($sformatf("v%0d_res0_tdata", i), res0_tdata, tbl[i].r0d);
      chk($sformatf("v%0d_res1_tvalid", i), res1_tvalid, tbl[i].r1v);
      chk($sformatf("v%0d_res1_tdata", i), res1_tdata, tbl[i].r1d);
      chk($sformatf("v%0d_outstanding", i), outstanding, tbl[i].outc);
      chk($sformatf("v%0d_orphan", i), orphan_err, tbl[i].orph);
    end
    req0_tvalid = 1'b0; req1_tvalid = 1'b0; cordic_m_tvalid = 1'b0;

    // Fresh reset, then fill against a stalled core
    @(negedge aclk); rst = 1'b1;
    #1; all_zero("reset2");
    @(negedge aclk); rst = 1'b0;
    @(posedge aclk); #1;
    req0_tvalid = 1'b1; req1_tvalid = 1'b1;
    req0_tdata = 16'h6600; req1_tdata = 16'h7700;
    hs = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_tready || req1_tready) hs++;
      @(posedge aclk); #1;
    end
    chk("full_handshakes", hs, 8);
    chk("full_rdy0", req0_tready, 0);
    chk("full_rdy1", req1_tready, 0);
    chk("full_outstanding", outstanding, 8);
    cordic_m_tvalid = 1'b1; cordic_m_tdata = 16'hE0FF;
    #1;
    chk("full_pop_rdy0", req0_tready, 0);
    chk("full_pop_rdy1", req1_tready, 0);
    @(posedge aclk); #1;
    cordic_m_tvalid = 1'b0;
    chk("after_pop_outstanding", outstanding, 7);
    chk("after_pop_res0", res0_tvalid, 1);
    chk("regrant_rdy0", req0_tready, 1);
    chk("regrant_rdy1", req1_tready, 0);
    @(posedge aclk); #1;
    chk("regrant_outstanding", outstanding, 8);
    chk("refull_rdy", req0_tready | req1_tready, 0);
    req0_tvalid = 1'b0; req1_tvalid = 1'b0;

    // Queued tags are now 1,0,1,0,... ; drain four
    for (int i = 0; i < 4; i++) begin
      cordic_m_tvalid = 1'b1; cordic_m_tdata = 16'hE000 + 16'(i);
      @(posedge aclk); #1;
      chk($sformatf("drain%0d_res1_tvalid", i), res1_tvalid, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("drain%0d_res0_tvalid", i), res0_tvalid, (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 0) chk($sformatf("drain%0d_res1_tdata", i), res1_tdata, 16'hE000 + 16'(i));
      else            chk($sformatf("drain%0d_res0_tdata", i), res0_tdata, 16'hE000 + 16'(i));
    end
    cordic_m_tvalid = 1'b0;
    chk("inflight_outstanding", outstanding, 4);

    // Reset with 4 in flight; the late results must be dropped
    @(negedge aclk);
    req0_tvalid = 1'b1; rst = 1'b1;
    #1; all_zero("rst_inflight");
    @(negedge aclk);
    rst = 1'b0; req0_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cordic_m_tvalid = 1'b1; cordic_m_tdata = 16'hF000 + 16'(i);
      @(posedge aclk); #1;
      chk($sformatf("late%0d_resv", i), res0_tvalid | res1_tvalid, 0);
    end
    cordic_m_tvalid = 1'b0;
    chk("late_orphan", orphan_err, 1);
    chk("late_outstanding", outstanding, 0);
    req1_tvalid = 1'b1; req1_tdata = 16'h5501;
    #1;
    chk("post_rst_rdy1", req1_tready, 1);
    @(posedge aclk); #1;
    req1_tvalid = 1'b0;
    chk("post_rst_s_tvalid", cordic_s_tvalid, 1);
    chk("post_rst_s_tdata", cordic_s_tdata, 16'h5501);
    chk("post_rst_outstanding", outstanding, 1);
    cordic_m_tvalid = 1'b1; cordic_m_tdata = 16'hD001;
    @(posedge aclk); #1;
    cordic_m_tvalid = 1'b0;
    chk("post_rst_res1_tvalid", res1_tvalid, 1);
    chk("post_rst_res1_tdata", res1_tdata, 16'hD001);
    chk("post_rst_res0_tvalid", res0_tvalid, 0);
    chk("post_rst_orphan", orphan_err, 1);
    chk("post_rst_outstanding0", outstanding, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge aclk) begin
    if (res0_tvalid && res1_tvalid) begin
      errors++;
      $display("FAIL dual_res_valid: got both res0_tvalid and res1_tvalid high, expected at most one, at %0t", $time);
    end
  end
endmodule
